video_timing_gen_p: RTL and testbench
=====================================

// Module: video_timing_gen_p
// PURPOSE
// Parametrised raster timing generator; successor to the fixed 720p video_sig_gen.
// Produces hcount/vcount, hsync/vsync, active-draw, new-frame and frame count for any mode.
// Adds selectable sync polarity, a configurable frame-count wrap, a line-start pulse and a
// DELAY-stage aligned output pipe matching downstream sprite/ROM latency ahead of TMDS encoders.
// PARAMETERS
// H_ACTIVE 1280 : visible pixels per line
// H_FP 110 / H_SYNC 40 / H_BP 220 : horizontal front porch / sync / back porch (pixels)
// V_ACTIVE 720 : visible lines per frame
// V_FP 5 / V_SYNC 5 / V_BP 20 : vertical front porch / sync / back porch (lines)
// SYNC_POL 1 : 1 = syncs active-high, 0 = active-low
// FC_WRAP 60 : frame counter counts 0..FC_WRAP-1 then wraps
// DELAY 0 : extra register stages on all outputs (0..16)
// Derived localparams: H_TOTAL, V_TOTAL, HW=$clog2(H_TOTAL), VW=$clog2(V_TOTAL), FW=$clog2(FC_WRAP)
// PORTS
// clk_pixel_in  in   1   pixel clock
// rst_in        in   1   synchronous active-high reset
// hcount_out    out  HW  horizontal position, 0..H_TOTAL-1
// vcount_out    out  VW  vertical position, 0..V_TOTAL-1
// hs_out        out  1   horizontal sync (polarity per SYNC_POL)
// vs_out        out  1   vertical sync (polarity per SYNC_POL)
// ad_out        out  1   active draw: hcount<H_ACTIVE && vcount<V_ACTIVE
// ls_out        out  1   one-cycle pulse at hcount==0 of every line
// nf_out        out  1   one-cycle pulse at hcount==H_ACTIVE && vcount==V_ACTIVE
// fc_out        out  FW  frame count
// BEHAVIOUR
// - Counters (h,v) registered; h increments every cycle, wraps H_TOTAL-1 -> 0; v increments on
//   h wrap, wraps V_TOTAL-1 -> 0. No enable; free-running outside reset.
// - Decode of all outputs is registered (1 cycle) then passes DELAY further stages; all outputs
//   of one sample stay mutually aligned. Total counter->pin latency = 1+DELAY.
// - hs active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs active iff
//   V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines; vs edges coincide with h==0).
// - fc increments in the same sample that carries nf_out=1; FC_WRAP-1 -> 0.
// - Reset: h=v=fc=0; every pipe stage cleared to hcount=0, vcount=0, ad=ls=nf=0, fc=0,
//   hs/vs at inactive level (=~SYNC_POL). First sample after release is (0,0): ad=1, ls=1,
//   appearing at outputs 1+DELAY cycles after the first edge with rst_in low.
// - Reset mid-frame: takes effect on next edge regardless of position; no partial pulses survive
//   (pipe fully cleared). Reset held N cycles -> outputs remain at reset values throughout.
// - Elaboration-time checks: all porch/sync params >=1, FC_WRAP>=2, DELAY<=16; else $error.
// - Widths: comparisons done at HW/VW bits; no truncation of H_TOTAL-1/V_TOTAL-1 permitted.
// STRUCTURE
// - Package video_pkg: timing_t struct {h_active,h_fp,h_sync,h_bp,v_active,v_fp,v_sync,v_bp},
//   TIMING_720P constant, sync-window helper functions.
// - Sub-module video_delay_pipe #(WIDTH,DELAY): clearable register chain for the packed
//   {hcount,vcount,hs,vs,ad,ls,nf,fc} word; DELAY=0 is a wire.
// TESTING
// - Small mode (H_ACTIVE=8,H_FP=2,H_SYNC=3,H_BP=1,V_ACTIVE=4,V_FP=1,V_SYNC=2,V_BP=1,DELAY=0):
//   hcount 0..13 wrap, hs high for hcount 10..12 only, vcount 0..7, vs high for vcount 5..6.
// - Same mode: ad_out count per frame == 32; nf_out exactly once per 112 cycles at (8,4);
//   ls_out once per 14 cycles at hcount=0.
// - FC_WRAP=3: run 4 frames -> fc_out sequence 1,2,0,1 on successive nf pulses.
// - SYNC_POL=0: hs/vs inverted vs SYNC_POL=1 run; during reset both read 1.
// - DELAY=3: outputs equal DELAY=0 instance's outputs shifted exactly 3 cycles, all fields.
// - Assert rst_in at (hcount=9,vcount=5) for 2 cycles -> outputs at reset values, then (0,0)
//   with ad=1 appears 1+DELAY cycles after release; no stray nf/ls/hs pulse during recovery.
// - Default 720p: H period 1650 cycles, frame 1237500 cycles, nf at (1280,720).

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster timing description and sync-window helpers for the video timing generators.
package video_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t TIMING_720P = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  function automatic int h_total(timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  // First pixel of the horizontal sync window
  function automatic int hs_start(timing_t t);
    return t.h_active + t.h_fp;
  endfunction

  // First pixel after the horizontal sync window
  function automatic int hs_end(timing_t t);
    return t.h_active + t.h_fp + t.h_sync;
  endfunction

  // First line of the vertical sync window
  function automatic int vs_start(timing_t t);
    return t.v_active + t.v_fp;
  endfunction

  // First line after the vertical sync window
  function automatic int vs_end(timing_t t);
    return t.v_active + t.v_fp + t.v_sync;
  endfunction

endpackage

// File: rtl/video_delay_pipe.sv
// Clearable register chain used to align all timing outputs with downstream pixel latency.
module video_delay_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DELAY   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DELAY == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst};
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_p [DELAY];

    // Shift the packed word one stage per clock; reset loads every stage with the idle word
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) stage_p[i] <= RST_VAL;
      end else begin
        stage_p[0] <= din;
        for (int i = 1; i < DELAY; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[DELAY-1];
  end

endmodule

// File: rtl/video_timing_gen_p.sv
// Parametrised raster timing generator: counters, registered decode, aligned output pipe.
module video_timing_gen_p
  import video_pkg::*;
#(
  parameter int H_ACTIVE = TIMING_720P.h_active,
  parameter int H_FP     = TIMING_720P.h_fp,
  parameter int H_SYNC   = TIMING_720P.h_sync,
  parameter int H_BP     = TIMING_720P.h_bp,
  parameter int V_ACTIVE = TIMING_720P.v_active,
  parameter int V_FP     = TIMING_720P.v_fp,
  parameter int V_SYNC   = TIMING_720P.v_sync,
  parameter int V_BP     = TIMING_720P.v_bp,
  parameter bit SYNC_POL = 1'b1,
  parameter int FC_WRAP  = 60,
  parameter int DELAY    = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL),
  localparam int FW      = $clog2(FC_WRAP)
) (
  input  logic          clk_pixel_in,
  input  logic          rst_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          ls_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out
);

  localparam timing_t TM = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP};

  // Every boundary is below H_TOTAL/V_TOTAL because each porch is at least one unit wide
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO   = HW'(hs_start(TM));
  localparam logic [HW-1:0] HS_HI   = HW'(hs_end(TM));
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_W = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO   = VW'(vs_start(TM));
  localparam logic [VW-1:0] VS_HI   = VW'(vs_end(TM));
  localparam logic [FW-1:0] FC_LAST = FW'(FC_WRAP - 1);

  localparam int PW = HW + VW + 5 + FW;
  localparam logic [PW-1:0] RST_WORD =
    {{HW{1'b0}}, {VW{1'b0}}, ~SYNC_POL, ~SYNC_POL, 3'b000, {FW{1'b0}}};

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
    begin : g_err_porch
    $error("video_timing_gen_p: porch and sync widths must be at least 1");
  end
  if (FC_WRAP < 2) begin : g_err_fc
    $error("video_timing_gen_p: FC_WRAP must be at least 2");
  end
  if (DELAY < 0 || DELAY > 16) begin : g_err_delay
    $error("video_timing_gen_p: DELAY must be within 0..16");
  end

  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;

  // Stage p0: free-running raster counters, v advances on every h wrap
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (h_p0 == H_LAST) begin
      h_p0 <= '0;
      v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
    end else begin
      h_p0 <= h_p0 + 1'b1;
    end
  end

  logic hs_act, vs_act, ad_c, ls_c, nf_c;
  assign hs_act = (h_p0 >= HS_LO) && (h_p0 < HS_HI);
  assign vs_act = (v_p0 >= VS_LO) && (v_p0 < VS_HI);
  assign ad_c   = (h_p0 < H_ACT_W) && (v_p0 < V_ACT_W);
  assign ls_c   = (h_p0 == '0);
  assign nf_c   = (h_p0 == H_ACT_W) && (v_p0 == V_ACT_W);

  logic [HW-1:0] hcount_p1;
  logic [VW-1:0] vcount_p1;
  logic          hs_p1, vs_p1, ad_p1, ls_p1, nf_p1;
  logic [FW-1:0] fc_p1;

  // Stage p1: registered decode; the frame count steps in the same sample that carries nf
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      ad_p1     <= 1'b0;
      ls_p1     <= 1'b0;
      nf_p1     <= 1'b0;
      fc_p1     <= '0;
    end else begin
      hcount_p1 <= h_p0;
      vcount_p1 <= v_p0;
      hs_p1     <= hs_act ? SYNC_POL : ~SYNC_POL;
      vs_p1     <= vs_act ? SYNC_POL : ~SYNC_POL;
      ad_p1     <= ad_c;
      ls_p1     <= ls_c;
      nf_p1     <= nf_c;
      if (nf_c) fc_p1 <= (fc_p1 == FC_LAST) ? '0 : fc_p1 + 1'b1;
    end
  end

  logic [PW-1:0] word_p1, word_out;
  assign word_p1 = {hcount_p1, vcount_p1, hs_p1, vs_p1, ad_p1, ls_p1, nf_p1, fc_p1};

  video_delay_pipe #(
    .WIDTH  (PW),
    .DELAY  (DELAY),
    .RST_VAL(RST_WORD)
  ) u_pipe (
    .clk (clk_pixel_in),
    .rst (rst_in),
    .din (word_p1),
    .dout(word_out)
  );

  assign {hcount_out, vcount_out, hs_out, vs_out, ad_out, ls_out, nf_out, fc_out} = word_out;

endmodule

// File: tb/tb_video_timing_gen_p.sv
// Bench for video_timing_gen_p: small modes (both polarities, DELAY 0 and 3) and 720p.
module tb_video_timing_gen_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_h, b_h;
  logic [2:0] a_v, b_v;
  logic [1:0] a_fc, b_fc;
  logic       a_hs, a_vs, a_ad, a_ls, a_nf;
  logic       b_hs, b_vs, b_ad, b_ls, b_nf;
  logic [10:0] c_h;
  logic [9:0]  c_v;
  logic [5:0]  c_fc;
  logic        c_hs, c_vs, c_ad, c_ls, c_nf;

  video_timing_gen_p #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .FC_WRAP(3), .DELAY(0)
  ) u_a (
    .clk_pixel_in(clk), .rst_in(rst), .hcount_out(a_h), .vcount_out(a_v),
    .hs_out(a_hs), .vs_out(a_vs), .ad_out(a_ad), .ls_out(a_ls), .nf_out(a_nf), .fc_out(a_fc)
  );

  video_timing_gen_p #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .FC_WRAP(3), .DELAY(3)
  ) u_b (
    .clk_pixel_in(clk), .rst_in(rst), .hcount_out(b_h), .vcount_out(b_v),
    .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .ls_out(b_ls), .nf_out(b_nf), .fc_out(b_fc)
  );

  video_timing_gen_p u_c (
    .clk_pixel_in(clk), .rst_in(rst), .hcount_out(c_h), .vcount_out(c_v),
    .hs_out(c_hs), .vs_out(c_vs), .ad_out(c_ad), .ls_out(c_ls), .nf_out(c_nf), .fc_out(c_fc)
  );

  typedef struct {
    int h, v, fc;
    bit hs, vs, ad, ls, nf;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output of the raster for the c-th pixel clock since reset release, from the mode numbers
  function automatic exp_t ref_sample(int c, int ha, int hf, int hsn, int hb,
                                      int va, int vf, int vsn, int vb, bit pol, int wrap);
    exp_t e;
    int ht, vt, frame, off, nfc;
    ht    = ha + hf + hsn + hb;
    vt    = va + vf + vsn + vb;
    frame = ht * vt;
    e.h   = c % ht;
    e.v   = (c / ht) % vt;
    e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsn) ? pol : !pol;
    e.vs  = (e.v >= va + vf && e.v < va + vf + vsn) ? pol : !pol;
    e.ad  = (e.h < ha) && (e.v < va);
    e.ls  = (e.h == 0);
    e.nf  = (e.h == ha) && (e.v == va);
    off   = va * ht + ha;
    nfc   = (c >= off) ? (c - off) / frame + 1 : 0;
    e.fc  = nfc % wrap;
    return e;
  endfunction

  function automatic exp_t ref_reset(bit pol);
    exp_t e;
    e.h = 0; e.v = 0; e.fc = 0;
    e.hs = !pol; e.vs = !pol;
    e.ad = 0; e.ls = 0; e.nf = 0;
    return e;
  endfunction

  function automatic longint pack(exp_t e);
    return (longint'(e.h) << 40) | (longint'(e.v) << 24) |
           (longint'(e.hs) << 20) | (longint'(e.vs) << 19) | (longint'(e.ad) << 18) |
           (longint'(e.ls) << 17) | (longint'(e.nf) << 16) | longint'(e.fc);
  endfunction

  function automatic longint pack_obs(int h, int v, bit hs, bit vs, bit ad, bit ls, bit nf,
                                      int fc);
    exp_t e;
    e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.ad = ad; e.ls = ls; e.nf = nf; e.fc = fc;
    return pack(e);
  endfunction

  // Reference: samples since release, pushed through a 1+DELAY latency that reset clears
  int   cyc = 0;
  exp_t ea, eb, ec;
  exp_t pb [3];

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
      ea = ref_reset(1'b1);
      eb = ref_reset(1'b0);
      ec = ref_reset(1'b1);
      for (int i = 0; i < 3; i++) pb[i] = ref_reset(1'b0);
    end else begin
      ea    = ref_sample(cyc, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 3);
      eb    = pb[2];
      pb[2] = pb[1];
      pb[1] = pb[0];
      pb[0] = ref_sample(cyc, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 3);
      ec    = ref_sample(cyc, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 60);
      cyc++;
    end
  end

  int tick = 0;

  task automatic step();
    @(negedge clk);
    tick++;
    chk("dut_a", pack_obs(int'(a_h), int'(a_v), a_hs, a_vs, a_ad, a_ls, a_nf, int'(a_fc)),
        pack(ea));
    chk("dut_b", pack_obs(int'(b_h), int'(b_v), b_hs, b_vs, b_ad, b_ls, b_nf, int'(b_fc)),
        pack(eb));
    chk("dut_c", pack_obs(int'(c_h), int'(c_v), c_hs, c_vs, c_ad, c_ls, c_nf, int'(c_fc)),
        pack(ec));
  endtask

  initial begin
    int ad_cnt, nf_cnt, ls_cnt, max_h, last_ls, period, found, n;
    int fc_seq [$];

    rst = 1'b1;
    repeat (3) step();
    chk("rst_a_hs", longint'(a_hs), 0);
    chk("rst_b_hs", longint'(b_hs), 1);
    chk("rst_b_vs", longint'(b_vs), 1);

    rst = 1'b0;
    step();
    chk("first_a", longint'({a_h, a_v, a_ad, a_ls}), longint'(9'b0000_000_11));
    chk("first_b_idle", longint'({b_ad, b_ls}), 0);
    repeat (3) step();
    chk("first_b", longint'({b_h, b_v, b_ad, b_ls}), longint'(9'b0000_000_11));

    ad_cnt = 0; nf_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 448; i++) begin
      step();
      ad_cnt += int'(a_ad);
      ls_cnt += int'(a_ls);
      if (a_nf) begin
        nf_cnt++;
        fc_seq.push_back(int'(a_fc));
        chk("nf_pos", longint'({a_h, a_v}), longint'({4'd8, 3'd4}));
      end
    end
    chk("ad_per_4frames", ad_cnt, 128);
    chk("nf_per_4frames", nf_cnt, 4);
    chk("ls_per_4frames", ls_cnt, 32);
    chk("fc_seq_len", fc_seq.size(), 4);
    if (fc_seq.size() == 4) begin
      chk("fc_seq0", fc_seq[0], 1);
      chk("fc_seq1", fc_seq[1], 2);
      chk("fc_seq2", fc_seq[2], 0);
      chk("fc_seq3", fc_seq[3], 1);
    end

    max_h = 0; last_ls = -1; period = 0;
    for (int i = 0; i < 3400; i++) begin
      step();
      if (int'(c_h) > max_h) max_h = int'(c_h);
      if (c_ls) begin
        if (last_ls >= 0) period = tick - last_ls;
        last_ls = tick;
      end
    end
    chk("c_hmax", max_h, 1649);
    chk("c_hperiod", period, 1650);

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (a_h == 4'd9 && a_v == 3'd5) found = 1;
    end
    chk("midrst_reach", found, 1);
    rst = 1'b1;
    step();
    chk("midrst_a0", pack_obs(int'(a_h), int'(a_v), a_hs, a_vs, a_ad, a_ls, a_nf, int'(a_fc)),
        pack(ref_reset(1'b1)));
    step();
    chk("midrst_b1", pack_obs(int'(b_h), int'(b_v), b_hs, b_vs, b_ad, b_ls, b_nf, int'(b_fc)),
        pack(ref_reset(1'b0)));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("recov_b_quiet", longint'({b_ls, b_nf, b_ad, b_hs}), longint'(4'b0001));
    end
    step();
    chk("recov_b_first", longint'({b_h, b_v, b_ad, b_ls}), longint'(9'b0000_000_11));

    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(1, 300));
      repeat (n) step();
      rst = 1'b1;
      n = int'($urandom_range(1, 4));
      repeat (n) step();
      rst = 1'b0;
    end
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
